// File: rtl/demux_scheduler.sv
// Round-robin 1:4 demultiplexing scheduler with valid/ready lanes and a sticky stall-timeout flag.
// Optional macro DEMUX_SCHED_SKIP_EN: at accept, skip ahead to the first ready lane from ptr.
module demux_scheduler #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             s1,
  output logic             s0,
  output logic             stall_err
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nx;
  logic [1:0]       ptr;
  logic [1:0]       target;
  logic [1:0]       sel;
  logic [WIDTH-1:0] hold;
  logic [7:0]       stall_cnt;
  logic [8:0]       cnt_inc;
  logic             done;
  logic             stall_hit;

  // Lane chosen at accept time.
`ifdef DEMUX_SCHED_SKIP_EN
  logic [1:0] idx;
  logic       found;
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && out_ready[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb sel = ptr;
`endif

  assign done      = (state == SEND) && out_ready[target];
  assign cnt_inc   = {1'b0, stall_cnt} + 9'd1;
  // The TIMEOUT-th SEND cycle flags the stall even if the handshake lands in it.
  assign stall_hit = (state == SEND) && (cnt_inc >= 9'(TIMEOUT));

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SEND;
      SEND:    if (done)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      target    <= 2'd0;
      hold      <= '0;
      stall_cnt <= 8'd0;
      stall_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        stall_cnt <= 8'd0;
        if (in_valid) begin
          hold   <= d;
          target <= sel;
        end
      end else begin
        if (!done && stall_cnt != 8'(TIMEOUT)) stall_cnt <= cnt_inc[7:0];
        if (done) ptr <= target + 2'd1;
      end
      if (stall_hit) stall_err <= 1'b1;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = 4'b0000;
    d0        = '0;
    d1        = '0;
    d2        = '0;
    d3        = '0;
    {s1, s0}  = ptr;
    if (state == SEND) begin
      out_valid[target] = 1'b1;
      {s1, s0}          = target;
      case (target)
        2'd0:    d0 = hold;
        2'd1:    d1 = hold;
        2'd2:    d2 = hold;
        default: d3 = hold;
      endcase
    end
  end

endmodule
